// File: rtl/func_test_sequencer.sv
// Self-test sequencer: walks x through 0..7, samples z/err after settling, checks against a truth table.
// Latency: done in the cycle starting 8*(SETTLE_CYCLES+1) edges after the start edge.
// Backpressure: none; start is taken only in IDLE and ignored while busy (no queuing).
module func_test_sequencer #(
    parameter logic [7:0] TRUTH_TABLE   = 8'b00111001,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic [2:0] x_out,
    input  logic       z_in,
    input  logic       err_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] fail_count_nxt;
    logic [2:0] first_fail_idx_nxt;
    logic       pass_nxt;
    logic       mismatch;

    // An asserted unit error flag counts as a failure even when z happens to match.
    assign mismatch = (z_in != TRUTH_TABLE[idx]) | err_in;

    assign x_out = idx;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= 3'd0;
            cnt            <= 4'd0;
            fail_count     <= 4'd0;
            first_fail_idx <= 3'd0;
            pass           <= 1'b0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            cnt            <= cnt_nxt;
            fail_count     <= fail_count_nxt;
            first_fail_idx <= first_fail_idx_nxt;
            pass           <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        idx_nxt            = idx;
        cnt_nxt            = cnt;
        fail_count_nxt     = fail_count;
        first_fail_idx_nxt = first_fail_idx;
        pass_nxt           = pass;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt          = SETTLE;
                    idx_nxt            = 3'd0;
                    cnt_nxt            = 4'd0;
                    fail_count_nxt     = 4'd0;
                    first_fail_idx_nxt = 3'd0;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == CNT_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    fail_count_nxt = fail_count + 4'd1;
                    if (fail_count == 4'd0) begin
                        first_fail_idx_nxt = idx;
                    end
                end
                if (idx == 3'd7) begin
                    // Verdict includes this final sample, so it uses the updated count.
                    state_nxt = DONE;
                    pass_nxt  = (fail_count_nxt == 4'd0);
                end else begin
                    state_nxt = SETTLE;
                    idx_nxt   = idx + 3'd1;
                    cnt_nxt   = 4'd0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
